// File: rtl/seg_pkg.sv
// seg_pkg: register map, digit-byte layout and segment font shared by the scan controller
package seg_pkg;
    localparam int ADDR_CTRL   = 'h0;
    localparam int ADDR_DATA0  = 'h4;
    localparam int ADDR_DATA1  = 'h8;
    localparam int ADDR_STATIC = 'hC;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLINK  = 1;
    localparam int CTRL_BRIGHT = 4;
    localparam int DIG_ON      = 7;
    localparam int DIG_DP      = 6;
    localparam int DIG_DASH    = 5;
    localparam int DIG_BLINK   = 4;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: CPU register read/write bus into the scan controller
interface seg_scan_ctrl_if #(parameter int ADDRWIDTH = 4);
    logic                 wr;
    logic [ADDRWIDTH-1:0] waddr;
    logic [31:0]          wdata;
    logic                 rd;
    logic [ADDRWIDTH-1:0] raddr;
    logic [31:0]          rdata;
    modport master (output wr, waddr, wdata, rd, raddr, input rdata);
    modport slave  (input wr, waddr, wdata, rd, raddr, output rdata);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: digit byte fields -> {dp, a..g}; off beats dash, dash beats the hex glyph
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic       on,
    input  logic       dp,
    input  logic       dash,
    input  logic [3:0] val,
    output logic [7:0] seg
);
    assign seg = !on ? {1'b0, SEG_BLANK} : {dp, dash ? SEG_DASH : HEX_FONT[val]};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: register-programmed multiplexed 7-segment scanner with blink and PWM brightness
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int ADDRWIDTH     = 4,
    parameter int DIGITS        = 8,
    parameter int SCAN_DIV      = 25000,
    parameter int BLINK_FRAMES  = 64,
    parameter bit CS_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    bus,
    output logic [DIGITS-1:0] scan_cs,
    output logic [7:0]        scan_out,
    output logic [7:0]        static_out
);
    localparam int CW   = $clog2(SCAN_DIV);
    localparam int IW   = $clog2(DIGITS);
    localparam int FW   = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP = SCAN_DIV / 16;
    localparam logic [DIGITS-1:0] CS_OFF = {DIGITS{CS_ACTIVE_LOW}};

    logic          en, blink_en, en_n, blink_n;
    logic [3:0]    bright, bright_n;
    logic [31:0]   data0, data1, rd_val;
    logic          wr_ctrl, wr_d0, wr_d1, wr_st;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n, cur, cur_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase, phase_n, live, live_n, tick, fend, lit, blank;
    logic [7:0]    dig, dig_n, sel, seg;
    logic [31:0]   win;

    // Address decode and next control values; next values let the display react on the write edge
    always_comb begin
        wr_ctrl  = bus.wr && bus.waddr == ADDRWIDTH'(ADDR_CTRL);
        wr_d0    = bus.wr && bus.waddr == ADDRWIDTH'(ADDR_DATA0);
        wr_d1    = bus.wr && bus.waddr == ADDRWIDTH'(ADDR_DATA1) && DIGITS == 8;
        wr_st    = bus.wr && bus.waddr == ADDRWIDTH'(ADDR_STATIC);
        en_n     = wr_ctrl ? bus.wdata[CTRL_EN] : en;
        blink_n  = wr_ctrl ? bus.wdata[CTRL_BLINK] : blink_en;
        bright_n = wr_ctrl ? bus.wdata[CTRL_BRIGHT +: 4] : bright;
        rd_val   = bus.raddr == ADDRWIDTH'(ADDR_CTRL) ? {24'b0, bright, 2'b0, blink_en, en} :
                   bus.raddr == ADDRWIDTH'(ADDR_DATA0) ? data0 :
                   (bus.raddr == ADDRWIDTH'(ADDR_DATA1) && DIGITS == 8) ? data1 :
                   bus.raddr == ADDRWIDTH'(ADDR_STATIC) ? {24'b0, static_out} : 32'b0;
    end

    // Register file; static_out is the STATIC register itself
    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            blink_en   <= 1'b0;
            bright     <= 4'h0;
            data0      <= 32'b0;
            data1      <= 32'b0;
            static_out <= 8'h00;
        end else begin
            en       <= en_n;
            blink_en <= blink_n;
            bright   <= bright_n;
            if (wr_d0) data0 <= bus.wdata;
            if (wr_d1) data1 <= bus.wdata;
            if (wr_st) static_out <= bus.wdata[7:0];
        end
    end

    // Read port samples the pre-write register contents and holds between reads
    always_ff @(posedge clk) begin
        if (rst) bus.rdata <= 32'b0;
        else if (bus.rd) bus.rdata <= rd_val;
    end

    // Scan next state: idx names the digit the coming tick will latch, cur the one on display
    always_comb begin
        tick    = en && cnt == CW'(SCAN_DIV - 1);
        fend    = tick && idx == IW'(DIGITS - 1);
        sel     = 8'({data1, data0} >> {idx, 3'b000});
        cnt_n   = !en_n ? '0 : !en ? cnt : tick ? '0 : cnt + CW'(1);
        idx_n   = !en_n ? '0 : !tick ? idx : fend ? '0 : idx + IW'(1);
        fcnt_n  = !en_n ? '0 : !fend ? fcnt : fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + FW'(1);
        phase_n = en_n && (phase ^ (fend && fcnt == FW'(BLINK_FRAMES - 1)));
        live_n  = en_n && (live || tick);
        cur_n   = tick ? idx : cur;
        dig_n   = tick ? sel : dig;
        win     = (32'(bright_n) + 32'd1) * 32'(STEP);
        lit     = bright_n == 4'hF || 32'(cnt_n) < win;
        blank   = blink_n && dig_n[DIG_BLINK] && phase_n;
    end

    seg_hex_decode u_dec (
        .on   (dig_n[DIG_ON]),
        .dp   (dig_n[DIG_DP]),
        .dash (dig_n[DIG_DASH]),
        .val  (dig_n[3:0]),
        .seg  (seg)
    );

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            cur      <= '0;
            fcnt     <= '0;
            phase    <= 1'b0;
            live     <= 1'b0;
            dig      <= 8'h00;
            scan_cs  <= CS_OFF;
            scan_out <= 8'h00;
        end else begin
            cnt      <= cnt_n;
            idx      <= idx_n;
            cur      <= cur_n;
            fcnt     <= fcnt_n;
            phase    <= phase_n;
            live     <= live_n;
            dig      <= dig_n;
            scan_cs  <= live_n ? CS_OFF ^ (DIGITS'(1) << cur_n) : CS_OFF;
            scan_out <= (live_n && lit && !blank) ? seg : 8'h00;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scanning, font, blink, PWM, write timing and register access
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] scan_cs;
    logic [7:0] scan_out, static_out;
    int errors = 0;
    int checks = 0;

    seg_scan_ctrl_if #(.ADDRWIDTH(4)) bus ();

    seg_scan_ctrl #(
        .ADDRWIDTH(4), .DIGITS(4), .SCAN_DIV(32), .BLINK_FRAMES(2), .CS_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .scan_cs(scan_cs), .scan_out(scan_out), .static_out(static_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr = 1'b1; bus.waddr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
        bus.rd = 1'b1; bus.raddr = a;
        @(negedge clk);
        bus.rd = 1'b0;
        d = bus.rdata;
    endtask

    task automatic wait_first;
        int n = 0;
        while (scan_cs == 4'hF && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("first_select_latency", n, 32);
    endtask

    task automatic chk_frame(input string tag, input logic [3:0][7:0] so);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            e = ~(4'b0001 << k);
            check($sformatf("%s_d%0d_cs", tag, k), scan_cs, e);
            check($sformatf("%s_d%0d_so", tag, k), scan_out, so[k]);
            repeat (32) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus.wr = 0; bus.rd = 0; bus.waddr = 0; bus.raddr = 0; bus.wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_cs", scan_cs, 4'hF);
        check("rst_so", scan_out, 8'h00);
        check("rst_static", static_out, 8'h00);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        // digit walk with hex 8,9,A,b then wrap
        reg_wr(4'h4, 32'h8B8A8988);
        reg_wr(4'h0, 32'hF1);
        wait_first();
        chk_frame("walk", {8'h1F, 8'h77, 8'h7B, 8'h7F});
        check("wrap_cs", scan_cs, 4'hE);
        check("wrap_so", scan_out, 8'h7F);
        repeat (10) @(negedge clk);
        reg_wr(4'h0, 32'h0);
        check("dis_cs", scan_cs, 4'hF);
        check("dis_so", scan_out, 8'h00);
        // dash, dp+5, off digit, zero byte
        reg_wr(4'h4, 32'h0005C5A0);
        reg_wr(4'h0, 32'hF1);
        wait_first();
        chk_frame("font", {8'h00, 8'h00, 8'hDB, 8'h01});
        // blink: two frames lit, two frames dark
        reg_wr(4'h0, 32'h0);
        reg_wr(4'h4, 32'h00000093);
        reg_wr(4'h0, 32'hF3);
        wait_first();
        for (int f = 0; f < 6; f++) begin
            check($sformatf("blink_f%0d", f), scan_out, ((f / 2) % 2) ? 8'h00 : 8'h79);
            repeat (128) @(negedge clk);
        end
        reg_wr(4'h0, 32'h0);
        reg_wr(4'h0, 32'hF1);
        wait_first();
        for (int f = 0; f < 4; f++) begin
            check($sformatf("noblink_f%0d", f), scan_out, 8'h79);
            repeat (128) @(negedge clk);
        end
        // PWM bright=3: 8 lit cycles out of 32, select held
        reg_wr(4'h0, 32'h0);
        reg_wr(4'h4, 32'h00000088);
        reg_wr(4'h0, 32'h31);
        wait_first();
        for (int c = 0; c < 32; c++) begin
            check($sformatf("pwm_cs_c%0d", c), scan_cs, 4'hE);
            check($sformatf("pwm_so_c%0d", c), scan_out, c < 8 ? 8'h7F : 8'h00);
            @(negedge clk);
        end
        check("pwm_next_cs", scan_cs, 4'hD);
        // write landing on digit 1's tick edge
        reg_wr(4'h0, 32'h0);
        reg_wr(4'h4, 32'h00008180);
        reg_wr(4'h0, 32'hF1);
        wait_first();
        repeat (31) @(negedge clk);
        reg_wr(4'h4, 32'h00008280);
        check("tickwr_old_cs", scan_cs, 4'hD);
        check("tickwr_old_so", scan_out, 8'h30);
        repeat (96) @(negedge clk);
        check("tickwr_d0_so", scan_out, 8'h7E);
        repeat (32) @(negedge clk);
        check("tickwr_new_cs", scan_cs, 4'hD);
        check("tickwr_new_so", scan_out, 8'h6D);
        repeat (5) @(negedge clk);
        reg_wr(4'h0, 32'h0);
        check("midslot_off_cs", scan_cs, 4'hF);
        check("midslot_off_so", scan_out, 8'h00);
        // register access
        reg_wr(4'hC, 32'h0000005A);
        check("static_out", static_out, 8'h5A);
        reg_rd(4'hC, r);
        check("rd_static", r, 32'h5A);
        reg_rd(4'h8, r);
        check("rd_data1_reserved", r, 32'h0);
        reg_wr(4'h8, 32'hFFFFFFFF);
        reg_rd(4'h8, r);
        check("rd_data1_after_wr", r, 32'h0);
        reg_rd(4'h1, r);
        check("rd_unmapped", r, 32'h0);
        reg_rd(4'h4, r);
        check("rd_data0", r, 32'h00008280);
        reg_wr(4'h0, 32'hFFFFFFFF);
        reg_rd(4'h0, r);
        check("rd_ctrl", r, 32'hF3);
        bus.wr = 1; bus.waddr = 4'hC; bus.wdata = 32'hA5;
        bus.rd = 1; bus.raddr = 4'hC;
        @(negedge clk);
        bus.wr = 0; bus.rd = 0;
        check("rdwr_same_old", bus.rdata, 32'h5A);
        check("rdwr_static_new", static_out, 8'hA5);
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.rdata, 32'h5A);
        // reset mid-frame
        reg_wr(4'h0, 32'h0);
        reg_wr(4'h0, 32'hF1);
        wait_first();
        repeat (40) @(negedge clk);
        check("pre_rst_so", scan_out, 8'h6D);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", scan_cs, 4'hF);
        check("midrst_so", scan_out, 8'h00);
        check("midrst_static", static_out, 8'h00);
        check("midrst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        reg_rd(4'h0, r);
        check("midrst_ctrl", r, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
